// File: rtl/dog_stream_core.sv
// Difference-of-Gaussians stream engine: paired source reads, per-pixel |a-b| / max / offset, credited return FIFOs.
// Latency: returns to wr_valid_o in 1 cycle (FIFOs bypass when empty); len+3 cycles start-to-done at full rate.
// Backpressure: wr_ready_i stalls the output register; reads stop at FIFO_DEPTH outstanding. Option: DOG_STATS_EN.

module dog_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_vld,
   input  logic [DW-1:0] push_dat,
   output logic          pop_vld,
   output logic [DW-1:0] pop_dat,
   input  logic          pop_rdy
);
   localparam int PW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   cnt;
   logic          empty, store, take;

   // An empty FIFO passes the incoming word straight through to the consumer.
   assign empty   = (cnt == '0);
   assign pop_vld = !empty || push_vld;
   assign pop_dat = empty ? push_dat : mem[rd_ptr];
   assign store   = push_vld && !(empty && pop_rdy);
   assign take    = pop_rdy && !empty;

   always_ff @(posedge clk) begin
      if (store) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (store) wr_ptr <= wr_ptr + 1'b1;
         if (take)  rd_ptr <= rd_ptr + 1'b1;
         case ({store, take})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

module dog_stream_core #(
   parameter int DW         = 8,
   parameter int AW         = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] len,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] src0_base,
   input  logic [AW-1:0] src1_base,
   input  logic [AW-1:0] dst_base,
   output logic          rd_valid_o,
   output logic [AW-1:0] ram0_rd_addr_o,
   output logic [AW-1:0] ram1_rd_addr_o,
   input  logic          ram0_valid_in,
   input  logic [DW-1:0] ram0_data_in,
   input  logic          ram1_valid_in,
   input  logic [DW-1:0] ram1_data_in,
   output logic          wr_valid_o,
   output logic [AW-1:0] wr_addr_o,
   output logic [DW-1:0] wr_data_o,
   input  logic          wr_ready_i,
`ifdef DOG_STATS_EN
   output logic [AW-1:0] sat_cnt_o,
`endif
   output logic          busy,
   output logic          done
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic signed [DW+1:0] MAXV = {2'b00, {DW{1'b1}}};
   localparam logic signed [DW+1:0] HALF = (DW+2)'(1) << (DW-1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] len_q, src0_q, src1_q, dst_q;
   logic [1:0]    mode_q;
   logic [AW-1:0] rd_idx, wr_idx, wr_cnt;
   logic [CW-1:0] outstanding;

   logic          start_acc, active, issue, pop, wr_hs, out_free;
   logic          last_rd, last_wr;
   logic          f0_vld, f1_vld;
   logic [DW-1:0] f0_dat, f1_dat;

   logic signed [DW+1:0] d, e, mag;
   logic [DW-1:0]        res;
   logic                 clamp;

   assign start_acc = (state_q == S_IDLE) && start;
   assign active    = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign issue     = (state_q == S_RUN) && (outstanding < CW'(FIFO_DEPTH));
   assign out_free  = !wr_valid_o || wr_ready_i;
   assign pop       = active && f0_vld && f1_vld && out_free;
   assign wr_hs     = wr_valid_o && wr_ready_i;
   assign last_rd   = issue && (rd_idx == len_q - 1'b1);
   assign last_wr   = wr_hs && (wr_cnt == len_q - 1'b1);

   assign rd_valid_o     = issue;
   assign ram0_rd_addr_o = src0_q + rd_idx;
   assign ram1_rd_addr_o = src1_q + rd_idx;
   assign busy           = active;
   assign done           = (state_q == S_DONE);

   // Returns arriving outside a job are discarded so they cannot pollute the next one.
   dog_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (ram0_valid_in && active),
      .push_dat (ram0_data_in),
      .pop_vld  (f0_vld),
      .pop_dat  (f0_dat),
      .pop_rdy  (pop)
   );

   dog_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .push_vld (ram1_valid_in && active),
      .push_dat (ram1_data_in),
      .pop_vld  (f1_vld),
      .pop_dat  (f1_dat),
      .pop_rdy  (pop)
   );

   always_comb begin
      d     = $signed({2'b00, f0_dat}) - $signed({2'b00, f1_dat});
      e     = d + HALF;
      mag   = d[DW+1] ? -d : d;
      res   = '0;
      clamp = 1'b0;
      case (mode_q)
         2'd1: begin
            if (d < 0) clamp = 1'b1;
            else       res   = d[DW-1:0];
         end
         2'd2: begin
            if (e < 0) begin
               clamp = 1'b1;
            end else if (e > MAXV) begin
               res   = {DW{1'b1}};
               clamp = 1'b1;
            end else begin
               res   = e[DW-1:0];
            end
         end
         default: begin
            if (mag > MAXV) begin
               res   = {DW{1'b1}};
               clamp = 1'b1;
            end else begin
               res   = mag[DW-1:0];
            end
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_RUN;
         S_RUN:   if (last_rd) state_d = S_DRAIN;
         S_DRAIN: if (last_wr) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q       <= '0;
         mode_q      <= '0;
         src0_q      <= '0;
         src1_q      <= '0;
         dst_q       <= '0;
         rd_idx      <= '0;
         wr_idx      <= '0;
         wr_cnt      <= '0;
         outstanding <= '0;
         wr_valid_o  <= 1'b0;
         wr_addr_o   <= '0;
         wr_data_o   <= '0;
      end else if (start_acc) begin
         len_q       <= len;
         mode_q      <= mode;
         src0_q      <= src0_base;
         src1_q      <= src1_base;
         dst_q       <= dst_base;
         rd_idx      <= '0;
         wr_idx      <= '0;
         wr_cnt      <= '0;
         outstanding <= '0;
      end else begin
         if (issue) rd_idx <= rd_idx + 1'b1;
         if (pop)   wr_idx <= wr_idx + 1'b1;
         if (wr_hs) wr_cnt <= wr_cnt + 1'b1;
         // A pop frees its credit at the same edge that a new read may consume one.
         case ({issue, pop})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
         if (pop) begin
            wr_valid_o <= 1'b1;
            wr_addr_o  <= dst_q + wr_idx;
            wr_data_o  <= res;
         end else if (wr_hs) begin
            wr_valid_o <= 1'b0;
         end
      end
   end

`ifdef DOG_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              sat_cnt_o <= '0;
      else if (start_acc)      sat_cnt_o <= '0;
      else if (pop && clamp)   sat_cnt_o <= sat_cnt_o + 1'b1;
   end
`else
   logic stats_unused;
   assign stats_unused = clamp;
`endif
endmodule

// File: tb/tb_dog_stream_core.sv
// Scoreboard bench for dog_stream_core: directed jobs push expected writes, a monitor pops on each write handshake.
module tb_dog_stream_core;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] len = '0;
   logic [1:0]  mode = '0;
   logic [15:0] src0_base = '0, src1_base = '0, dst_base = '0;
   logic        rd_valid_o;
   logic [15:0] ram0_rd_addr_o, ram1_rd_addr_o;
   logic        ram0_valid_in = 1'b0, ram1_valid_in = 1'b0;
   logic [7:0]  ram0_data_in = '0, ram1_data_in = '0;
   logic        wr_valid_o;
   logic [15:0] wr_addr_o;
   logic [7:0]  wr_data_o;
   logic        wr_ready_i = 1'b1;
   logic        busy, done;
`ifdef DOG_STATS_EN
   logic [15:0] sat_cnt_o;
`endif

   dog_stream_core #(.DW(8), .AW(16), .FIFO_DEPTH(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .len            (len),
      .mode           (mode),
      .src0_base      (src0_base),
      .src1_base      (src1_base),
      .dst_base       (dst_base),
      .rd_valid_o     (rd_valid_o),
      .ram0_rd_addr_o (ram0_rd_addr_o),
      .ram1_rd_addr_o (ram1_rd_addr_o),
      .ram0_valid_in  (ram0_valid_in),
      .ram0_data_in   (ram0_data_in),
      .ram1_valid_in  (ram1_valid_in),
      .ram1_data_in   (ram1_data_in),
      .wr_valid_o     (wr_valid_o),
      .wr_addr_o      (wr_addr_o),
      .wr_data_o      (wr_data_o),
      .wr_ready_i     (wr_ready_i),
`ifdef DOG_STATS_EN
      .sat_cnt_o      (sat_cnt_o),
`endif
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int cyc = 0;
   logic [23:0] sb [$];
   logic [15:0] rd_addr_log [$];
   int rd_cnt = 0, wr_acc = 0;
   int d0 = 1, d1 = 1;
   bit ready_toggle = 1'b0, chk_outst = 1'b0, inj0 = 1'b0;
   logic [7:0] mem0 [0:65535];
   logic [7:0] mem1 [0:65535];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // RAM models with per-channel return delay; also drives wr_ready_i
   logic       pv0 [8], pv1 [8];
   logic [7:0] pd0 [8], pd1 [8];
   initial begin
      for (int i = 0; i < 8; i++) begin pv0[i] = 0; pv1[i] = 0; pd0[i] = 0; pd1[i] = 0; end
      forever begin
         @(negedge clk);
         for (int i = 7; i > 0; i--) begin
            pv0[i] = pv0[i-1]; pd0[i] = pd0[i-1];
            pv1[i] = pv1[i-1]; pd1[i] = pd1[i-1];
         end
         pv0[0] = rd_valid_o; pd0[0] = mem0[ram0_rd_addr_o];
         pv1[0] = rd_valid_o; pd1[0] = mem1[ram1_rd_addr_o];
         if (rd_valid_o) begin
            rd_cnt++;
            rd_addr_log.push_back(ram0_rd_addr_o);
         end
         if (!rst_n)
            for (int i = 0; i < 8; i++) begin pv0[i] = 0; pv1[i] = 0; end
         @(posedge clk);
         #1;
         ram0_valid_in = pv0[d0-1] | inj0;
         ram0_data_in  = inj0 ? 8'h55 : pd0[d0-1];
         inj0 = 1'b0;
         ram1_valid_in = pv1[d1-1];
         ram1_data_in  = pd1[d1-1];
         wr_ready_i    = ready_toggle ? ~wr_ready_i : 1'b1;
      end
   end

   // Monitor: write handshakes against scoreboard, stall stability, outstanding bound
   int iss_m = 0, acc_m = 0;
   bit stall_prev = 0;
   logic [15:0] prev_addr;
   logic [7:0]  prev_data;
   initial forever begin
      logic [23:0] e;
      int o;
      @(negedge clk);
      if (!rst_n) begin
         stall_prev = 0; iss_m = 0; acc_m = 0;
      end else begin
         if (chk_outst) begin
            o = iss_m - acc_m - int'(wr_valid_o);
            chk("outstanding_le_4", 32'(o <= 4), 1);
         end
         if (stall_prev) begin
            chk("stall_vld", 32'(wr_valid_o), 1);
            chk("stall_addr", 32'(wr_addr_o), 32'(prev_addr));
            chk("stall_data", 32'(wr_data_o), 32'(prev_data));
         end
         if (wr_valid_o && wr_ready_i) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_write actual addr=%0h data=%0d required none", wr_addr_o, wr_data_o);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", 32'(wr_addr_o), 32'(e[23:8]));
               chk("wr_data", 32'(wr_data_o), 32'(e[7:0]));
            end
            acc_m++; wr_acc++;
         end
         if (rd_valid_o) iss_m++;
         stall_prev = wr_valid_o && !wr_ready_i;
         prev_addr  = wr_addr_o;
         prev_data  = wr_data_o;
      end
   end

   task automatic load(input logic [15:0] b0, input logic [15:0] b1,
                       input logic [7:0] s0 [8], input logic [7:0] s1 [8]);
      logic [15:0] a;
      for (int i = 0; i < 8; i++) begin
         a = b0 + 16'(i); mem0[a] = s0[i];
         a = b1 + 16'(i); mem1[a] = s1[i];
      end
   endtask

   task automatic run_job(input logic [15:0] n, input logic [1:0] m,
                          input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] bd,
                          input logic [7:0] ex [8], input int exp_lat, input bit busy_start);
      int s;
      bit got;
      for (int i = 0; i < int'(n); i++) sb.push_back({bd + 16'(i), ex[i]});
      @(posedge clk); #1;
      start = 1'b1; len = n; mode = m; src0_base = b0; src1_base = b1; dst_base = bd;
      s = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      if (busy_start) begin
         @(posedge clk); #1;
         start = 1'b1; len = 16'd2; mode = 2'd1; dst_base = 16'h0500;
         @(posedge clk); #1;
         start = 1'b0;
      end
      got = 0;
      for (int k = 0; k < 300 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1;
      end
      chk("done_seen", 32'(got), 1);
      if (got && exp_lat >= 0) chk("done_latency", 32'(cyc - s), 32'(exp_lat));
      chk("busy_at_done", 32'(busy), 0);
      chk("writes_complete", 32'(sb.size()), 0);
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_rd_valid"}, 32'(rd_valid_o), 0);
      chk({tag, "_rd_addr0"}, 32'(ram0_rd_addr_o), 0);
      chk({tag, "_rd_addr1"}, 32'(ram1_rd_addr_o), 0);
      chk({tag, "_wr_valid"}, 32'(wr_valid_o), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr_o), 0);
      chk({tag, "_wr_data"}, 32'(wr_data_o), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
`ifdef DOG_STATS_EN
      chk({tag, "_sat_cnt"}, 32'(sat_cnt_o), 0);
`endif
   endtask

   initial begin
      logic [7:0] s0_t [8]  = '{8'd10, 8'd200, 8'd0, 8'd255, 8'd10, 8'd200, 8'd0, 8'd255};
      logic [7:0] s1_t [8]  = '{8'd20, 8'd100, 8'd255, 8'd0, 8'd20, 8'd100, 8'd255, 8'd0};
      logic [7:0] ex_m0 [8] = '{8'd10, 8'd100, 8'd255, 8'd255, 8'd10, 8'd100, 8'd255, 8'd255};
      logic [7:0] ex_m1 [8] = '{8'd0, 8'd100, 8'd0, 8'd255, 8'd0, 8'd100, 8'd0, 8'd255};
      logic [7:0] ex_m2 [8] = '{8'd118, 8'd228, 8'd0, 8'd255, 8'd118, 8'd228, 8'd0, 8'd255};
      logic [15:0] wrap_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
      int r0;
      bit got;

      load(16'h0100, 16'h0200, s0_t, s1_t);
      load(16'hFFFE, 16'h0010, s0_t, s1_t);
      #23;
      chk_outputs_zero("reset");
      @(negedge clk); #1;
      rst_n = 1'b1;

      // Basic modes at full rate
      run_job(16'd4, 2'd0, 16'h0100, 16'h0200, 16'h0300, ex_m0, 7, 1'b0);
      run_job(16'd4, 2'd1, 16'h0100, 16'h0200, 16'h0310, ex_m1, 7, 1'b0);
      run_job(16'd4, 2'd2, 16'h0100, 16'h0200, 16'h0320, ex_m2, 7, 1'b0);
`ifdef DOG_STATS_EN
      chk("sat_cnt_mode2", 32'(sat_cnt_o), 2);
      repeat (3) @(negedge clk);
      chk("sat_cnt_hold", 32'(sat_cnt_o), 2);
`endif
      run_job(16'd4, 2'd3, 16'h0100, 16'h0200, 16'h0330, ex_m0, 7, 1'b0);

      // Skewed returns and toggling write ready
      d1 = 3; ready_toggle = 1'b1; chk_outst = 1'b1;
      run_job(16'd8, 2'd0, 16'h0100, 16'h0200, 16'h0400, ex_m0, -1, 1'b0);
      repeat (4) @(negedge clk);
      d1 = 1; ready_toggle = 1'b0; chk_outst = 1'b0;
      repeat (2) @(negedge clk);

      // Empty job, then a start attempt while busy
      r0 = rd_cnt;
      run_job(16'd0, 2'd0, 16'h0100, 16'h0200, 16'h0600, ex_m0, 1, 1'b0);
      chk("empty_no_reads", 32'(rd_cnt - r0), 0);
      run_job(16'd4, 2'd0, 16'h0100, 16'h0200, 16'h0700, ex_m0, 7, 1'b1);
      r0 = rd_cnt;
      repeat (10) @(negedge clk);
      chk("ignored_start_no_reads", 32'(rd_cnt - r0), 0);

      // Stray return while idle, then address wrap
      @(negedge clk);
      inj0 = 1'b1;
      repeat (3) @(negedge clk);
      rd_addr_log.delete();
      run_job(16'd4, 2'd0, 16'hFFFE, 16'h0010, 16'h0800, ex_m0, 7, 1'b0);
      chk("wrap_read_count", 32'(rd_addr_log.size()), 4);
      for (int i = 0; i < 4 && i < rd_addr_log.size(); i++)
         chk("wrap_addr", 32'(rd_addr_log[i]), 32'(wrap_a[i]));

      // Reset mid-job after two writes
      r0 = wr_acc;
      for (int i = 0; i < 4; i++) sb.push_back({16'h0900 + 16'(i), ex_m0[i]});
      @(posedge clk); #1;
      start = 1'b1; len = 16'd4; mode = 2'd0;
      src0_base = 16'h0100; src1_base = 16'h0200; dst_base = 16'h0900;
      @(posedge clk); #1;
      start = 1'b0;
      got = 0;
      for (int k = 0; k < 50 && !got; k++) begin
         @(negedge clk);
         if (wr_acc - r0 >= 2) got = 1;
      end
      chk("two_writes_before_reset", 32'(got), 1);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_outputs_zero("midjob_reset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_done_in_reset", 32'(done), 0);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("no_done_after_reset", 32'(done), 0);
         chk("no_wr_after_reset", 32'(wr_valid_o), 0);
      end
      run_job(16'd4, 2'd1, 16'h0100, 16'h0200, 16'h0A00, ex_m1, 7, 1'b0);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
